load_store_unit: RTL
====================

# load_store_unit

Data-side initiator for port 1 (read + write) of the core's dual-port word memory. Accepts one byte, halfword or word load/store at a time from the execute stage and translates it into word-wide memory cycles. The memory has no byte enables, so sub-word stores are read-modify-write. Load results are sign- or zero-extended, and misaligned accesses are flagged without touching memory.

## Interface
- No parameters. Address and data widths are fixed at 32.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready at clk edge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (ignored for word loads and stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for sub-word stores
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result; 0 for stores and faults
- rsp_fault  out  1  misaligned or illegal-size request; qualified by rsp_valid
- mem_read  out  1  to memory port 1 read strobe
- mem_write  out  1  to memory port 1 write strobe
- mem_address  out  32  {addr[31:2], 2'b00}
- mem_write_data  out  32  word to write; meaningful only while mem_write=1
- mem_read_data  in  32  registered memory output; valid the cycle after mem_read=1

## Operation
- States: IDLE, READ, CAPTURE, WRITE, RESP. Reset enters IDLE.
- req_ready = 1 only in IDLE. All req_* fields are captured at acceptance, and changes while busy are ignored. Only one request is outstanding at a time.
- Fault check at acceptance: size 11, half with addr[0]=1, or word with addr[1:0]≠0. On a fault: IDLE→RESP with rsp_fault=1, rsp_rdata=0, and no mem_read/mem_write.
- Load: IDLE→READ→CAPTURE→RESP.
- Word store: IDLE→WRITE→RESP.
- Sub-word store: IDLE→READ→CAPTURE→WRITE→RESP.
- READ drives mem_read=1. WRITE drives mem_write=1. In every other state both strobes are 0, and they are never both 1.
- CAPTURE for a load:
  - byte: lane = addr[1:0], bits [8·lane+7 : 8·lane].
  - half: bits [16·addr[1]+15 : 16·addr[1]].
  - Sign-extend unless req_unsigned, then register into rsp_rdata.
- CAPTURE for a sub-word store: merge into mem_read_data, replacing only the addressed byte/half lane with wdata[7:0] / wdata[15:0]. The result is registered as mem_write_data.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. No response backpressure; the consumer must take the pulse.
- mem_address holds the captured word address from the cycle after acceptance until the next acceptance.
- Read-modify-write is atomic with respect to this port only. Port-2 fetches may observe the old word between READ and WRITE, which is acceptable.

## Timing
- Cycle 0 is the accept edge. rsp_valid is asserted in:
  - fault: cycle 1
  - word store: cycle 2
  - load: cycle 3
  - sub-word store: cycle 4
- The next request is accepted at the earliest in the cycle after RESP.
- Reset values: req_ready=0 while rst=1 and 1 from the first cycle after; rsp_valid=0, rsp_fault=0, rsp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- Reset mid-operation: abandon the request. No later mem_write and no rsp_valid are issued. A strobe already driven in the cycle rst is sampled is not retracted.
- rsp_rdata and rsp_fault hold their values between pulses and are meaningful only with rsp_valid.
- Outputs are state-decoded from registers, with no combinational path from req_* to mem_*. req_ready depends only on state.

## Test plan
- Word store to 0x10 with 0xDEADBEEF:
  - cycle 1: mem_write=1, mem_address=0x10, data 0xDEADBEEF.
  - cycle 2: rsp_valid=1, fault=0.
  - A following word load from 0x10 returns 0xDEADBEEF at cycle 3.
- Loads from word 0xDEADBEEF at 0x10:
  - signed byte at 0x13 → 0xFFFFFFDE
  - unsigned byte at 0x13 → 0x000000DE
  - signed half at 0x12 → 0xFFFFDEAD
  - unsigned half at 0x10 → 0x0000BEEF
  - signed byte at 0x10 → 0xFFFFFFEF
- Byte store 0x12345677 to 0x11 over 0xDEADBEEF:
  - mem_read in cycle 1, mem_write in cycle 3 with 0xDEAD77EF, rsp in cycle 4.
  - Then half store 0x0000CAFE to 0x12 writes 0xCAFE77EF.
- Faults: word at 0x06, half at 0x05, size 11 at 0x00.
  - Each gives rsp_valid=1 with rsp_fault=1 and rsp_rdata=0 at cycle 1.
  - mem_read and mem_write stay 0 throughout.
- req_valid held high with fields changed every cycle:
  - req_ready=1 only in IDLE.
  - Each accepted request uses the values present at its accept edge.
  - No request is dropped or duplicated.
- rst pulsed for 1 cycle during CAPTURE of a byte store:
  - no mem_write and no rsp_valid follow.
  - All outputs return to reset values, and req_ready=1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-side load/store initiator for memory port 1.
// Word-wide cycles, read-modify-write for sub-word stores, extension of loads.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_t      state;
    state_t      state_next;

    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        fault;
    logic        word_store;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] wdata_sh;
    logic [31:0] merged;

    // Strobes and handshakes decode straight from the state register.
    assign req_ready = (state == IDLE) && !rst;
    assign mem_read  = (state == READ);
    assign mem_write = (state == WRITE);
    assign rsp_valid = (state == RESP);

    assign accept     = req_valid && req_ready;
    assign word_store = req_write && (req_size == SZ_WORD);

    // Alignment / size legality of the incoming request.
    always_comb begin
        fault = 1'b0;
        case (req_size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = req_addr[0];
            SZ_WORD: fault = |req_addr[1:0];
            SZ_BAD:  fault = 1'b1;
            default: fault = 1'b1;
        endcase
    end

    // Lane shift: half accesses are even, so the byte shift also serves them.
    assign shamt   = {lane_q, 3'b000};
    assign shifted = mem_read_data >> shamt;

    // Extract and extend the addressed lane of the fetched word.
    always_comb begin
        load_ext = shifted;
        case (size_q)
            SZ_BYTE: begin
                if (unsigned_q)
                    load_ext = {24'h000000, shifted[7:0]};
                else
                    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                if (unsigned_q)
                    load_ext = {16'h0000, shifted[15:0]};
                else
                    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            end
            default: load_ext = shifted;
        endcase
    end

    // Replace only the addressed byte/half lane of the fetched word.
    always_comb begin
        lane_mask = 32'h0000_0000;
        if (size_q == SZ_BYTE)
            lane_mask = 32'h0000_00FF << shamt;
        else
            lane_mask = 32'h0000_FFFF << shamt;
        wdata_sh = wdata_q << shamt;
        merged   = (mem_read_data & ~lane_mask) | (wdata_sh & lane_mask);
    end

    // Next-state sequencing of one request.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault)
                        state_next = RESP;
                    else if (word_store)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = CAPTURE;
            CAPTURE: state_next = write_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Request capture, load result and store word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q        <= 1'b0;
            size_q         <= 2'b00;
            unsigned_q     <= 1'b0;
            lane_q         <= 2'b00;
            wdata_q        <= 32'h0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
            rsp_rdata      <= 32'h0;
            rsp_fault      <= 1'b0;
        end else if (accept) begin
            write_q     <= req_write;
            size_q      <= req_size;
            unsigned_q  <= req_unsigned;
            lane_q      <= req_addr[1:0];
            wdata_q     <= req_wdata;
            mem_address <= {req_addr[31:2], 2'b00};
            rsp_rdata   <= 32'h0;
            rsp_fault   <= fault;
            if (word_store)
                mem_write_data <= req_wdata;
        end else if (state == CAPTURE) begin
            if (write_q)
                mem_write_data <= merged;
            else
                rsp_rdata <= load_ext;
        end
    end

endmodule
